// File: rtl/bcd_pkg.sv
// Shared BCD constants and controller state encoding for the serial BCD adder.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_ADJ = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_serial_add_ctrl_if.sv
// Start handshake, operand and result bundle for the serial BCD adder.
interface bcd_serial_add_ctrl_if #(
    parameter int NDIG = 4
);
    logic                start;
    logic [4*NDIG-1:0]   a;
    logic [4*NDIG-1:0]   b;
    logic                cin;
    logic                busy;
    logic                done;
    logic [4*NDIG-1:0]   sum;
    logic                cout;
    logic                invalid;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, invalid
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, invalid
    );
endinterface

// File: rtl/bcd_digit_add.sv
// One-digit BCD adder: binary add, then +6 correction with carry when above 9.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [4:0] t;

    always_comb begin
        t = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        if (t > {1'b0, BCD_MAX}) begin
            s    = t[3:0] + BCD_ADJ;
            cout = 1'b1;
        end else begin
            s    = t[3:0];
            cout = 1'b0;
        end
    end
endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Serial BCD adder controller: one digit per clock through a shared digit adder,
// LSD first, with a rippled decimal carry register.
module bcd_serial_add_ctrl
    import bcd_pkg::*;
#(
    parameter int NDIG = 4,
    parameter int CW   = 3
) (
    input  logic                clk,
    input  logic                rst,
    bcd_serial_add_ctrl_if.slave bus
);
    state_t            state, state_nxt;
    logic              accept, last;
    logic [CW-1:0]     idx;
    logic [4*NDIG-1:0] a_r, b_r, sum_r;
    logic              carry, cout_r, invalid_r, busy_r, done_r, nonbcd;
    logic [3:0]        da, db, ds;
    logic              dc;

    assign da   = a_r[4*idx +: 4];
    assign db   = b_r[4*idx +: 4];
    assign last = (idx == CW'(NDIG - 1));

    bcd_digit_add u_digit (
        .a    (da),
        .b    (db),
        .cin  (carry),
        .s    (ds),
        .cout (dc)
    );

    always_comb begin
        nonbcd = 1'b0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (bus.a[4*i +: 4] > BCD_MAX || bus.b[4*i +: 4] > BCD_MAX)
                nonbcd = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                accept    = 1'b1;
                state_nxt = RUN;
            end
            RUN:  if (last) state_nxt = DONE;
            DONE: begin
                accept    = bus.start;
                state_nxt = bus.start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // busy/done are flopped from the next-state decode so they line up with state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            idx       <= '0;
            a_r       <= '0;
            b_r       <= '0;
            carry     <= 1'b0;
            sum_r     <= '0;
            cout_r    <= 1'b0;
            invalid_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt == RUN);
            done_r <= (state_nxt == DONE);
            if (accept) begin
                a_r       <= bus.a;
                b_r       <= bus.b;
                carry     <= bus.cin;
                idx       <= '0;
                sum_r     <= '0;
                cout_r    <= 1'b0;
                invalid_r <= nonbcd;
            end else if (state == RUN) begin
                sum_r[4*idx +: 4] <= ds;
                carry             <= dc;
                if (last) cout_r <= dc;
                else      idx    <= idx + CW'(1);
            end
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.sum     = sum_r;
    assign bus.cout    = cout_r;
    assign bus.invalid = invalid_r;
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed bench for bcd_serial_add_ctrl: cycle model plus result scoreboard.
module tb_bcd_serial_add_ctrl;
    localparam int NDIG = 4;
    localparam int CW   = 3;

    typedef struct packed {
        logic [4*NDIG-1:0] sum;
        logic              cout;
        logic              invalid;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   fails  = 0;
    int   m_run  = 0;
    logic m_done = 1'b0;
    int   ndone  = 0;
    res_t last_res = '0;
    res_t sb[$];

    bcd_serial_add_ctrl_if #(.NDIG(NDIG)) bus ();

    bcd_serial_add_ctrl #(.NDIG(NDIG), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [4*NDIG-1:0] a, input logic [4*NDIG-1:0] b,
                                   input logic cin);
        res_t        r;
        logic        c;
        int unsigned da, db, t;
        r = '0;
        c = cin;
        for (int i = 0; i < NDIG; i++) begin
            da = int'(a[4*i +: 4]);
            db = int'(b[4*i +: 4]);
            if (da > 9 || db > 9) r.invalid = 1'b1;
            t = da + db + int'(c);
            if (t > 9) begin
                r.sum[4*i +: 4] = 4'((t + 6) % 16);
                c = 1'b1;
            end else begin
                r.sum[4*i +: 4] = 4'(t);
                c = 1'b0;
            end
        end
        r.cout = c;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run    = 0;
        m_done   = 1'b0;
        last_res = '0;
        sb.delete();
    endtask

    // Advance one clock; the model decides acceptance from the inputs driven now.
    task automatic tick();
        res_t e;
        if (m_run == 0 && bus.start === 1'b1) begin
            sb.push_back(model(bus.a, bus.b, bus.cin));
            m_run  = NDIG;
            m_done = 1'b0;
        end else if (m_run > 0) begin
            m_run--;
            m_done = (m_run == 0);
        end else begin
            m_done = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("busy", 64'(bus.busy), 64'(m_run != 0));
        chk("done", 64'(bus.done), 64'(m_done));
        if (m_done) begin
            ndone++;
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("sum", 64'(bus.sum), 64'(e.sum));
                chk("cout", 64'(bus.cout), 64'(e.cout));
                chk("invalid", 64'(bus.invalid), 64'(e.invalid));
                last_res = e;
            end
        end else if (m_run == 0) begin
            chk("hold_sum", 64'(bus.sum), 64'(last_res.sum));
            chk("hold_cout", 64'(bus.cout), 64'(last_res.cout));
            chk("hold_invalid", 64'(bus.invalid), 64'(last_res.invalid));
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m_run != 0 || m_done) && n < 50) begin
            tick();
            n++;
        end
        chk("drain_timeout", 64'(n >= 50), 64'(0));
    endtask

    task automatic launch(input logic [4*NDIG-1:0] a, input logic [4*NDIG-1:0] b,
                          input logic cin);
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        int d0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_sum", 64'(bus.sum), 64'(0));
        chk("rst_cout", 64'(bus.cout), 64'(0));
        chk("rst_invalid", 64'(bus.invalid), 64'(0));
        rst = 1'b0;
        model_reset();

        // Idle after reset: no done, outputs stay zero.
        repeat (20) tick();
        chk("idle_no_done", 64'(ndone), 64'(0));

        // Basic carry ripple, busy width and done latency.
        launch(16'h0999, 16'h0001, 1'b0);
        busy_cnt = (bus.busy === 1'b1) ? 1 : 0;
        while (m_run != 0) begin
            tick();
            if (bus.busy === 1'b1) busy_cnt++;
        end
        chk("busy_cycles", 64'(busy_cnt), 64'(NDIG));
        chk("done_after_busy", 64'(bus.done), 64'(1));
        chk("sum_1000", 64'(bus.sum), 64'(16'h1000));
        drain();

        // Full carry chain, then a back-to-back start in the DONE cycle.
        launch(16'h9999, 16'h9999, 1'b1);
        while (m_run != 0) tick();
        chk("b2b_in_done", 64'(bus.done), 64'(1));
        chk("sum_9999", 64'(bus.sum), 64'(16'h9999));
        launch(16'h9999, 16'h0001, 1'b0);
        chk("b2b_accepted", 64'(bus.busy), 64'(1));
        drain();
        chk("sum_0000", 64'(bus.sum), 64'(16'h0000));
        chk("cout_b2b", 64'(bus.cout), 64'(1));

        // Non-BCD operand digit, then a clean operand clearing the flag.
        launch(16'h000F, 16'h0000, 1'b0);
        drain();
        chk("sum_0015", 64'(bus.sum), 64'(16'h0015));
        chk("invalid_set", 64'(bus.invalid), 64'(1));
        launch(16'h0009, 16'h0009, 1'b0);
        drain();
        chk("sum_0018", 64'(bus.sum), 64'(16'h0018));
        chk("invalid_clr", 64'(bus.invalid), 64'(0));

        // start held high with operands changing every cycle.
        d0 = ndone;
        bus.start = 1'b1;
        for (int i = 0; i < 3 * (NDIG + 1); i++) begin
            for (int d = 0; d < NDIG; d++) begin
                bus.a[4*d +: 4] = 4'($urandom_range(0, 9));
                bus.b[4*d +: 4] = 4'($urandom_range(0, 9));
            end
            bus.cin = 1'($urandom_range(0, 1));
            tick();
        end
        bus.start = 1'b0;
        drain();
        chk("held_start_dones", 64'(ndone - d0), 64'(3));

        // Asynchronous reset in the second RUN cycle.
        launch(16'h1111, 16'h2222, 1'b1);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 64'(bus.busy), 64'(0));
        chk("arst_done", 64'(bus.done), 64'(0));
        chk("arst_sum", 64'(bus.sum), 64'(0));
        chk("arst_cout", 64'(bus.cout), 64'(0));
        chk("arst_invalid", 64'(bus.invalid), 64'(0));
        @(posedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        tick();
        launch(16'h1234, 16'h4321, 1'b0);
        drain();
        chk("sum_5555", 64'(bus.sum), 64'(16'h5555));
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/bcd_serial_add_ctrl.md
Name: bcd_serial_add_ctrl

Overview:
- Sequences a single one-digit BCD adder over an NDIG-digit packed-BCD operand pair, least significant digit first, one digit per clock.
- Captures operands on a start handshake, iterates a digit counter and ripples the decimal carry through a register.
- Presents the full sum with carry-out and a one-cycle done pulse.
- Lets the lab datapath reuse one BCD digit adder instead of instantiating NDIG of them.

Parameters:
- NDIG, 4, number of BCD digits per operand (NDIG ≥ 1).
- CW, 3, digit-counter width; must satisfy 2**CW ≥ NDIG.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset.
- start  input  1  request to begin an addition; sampled only when busy=0.
- a  input  4*NDIG  operand A, packed BCD, digit 0 in bits [3:0].
- b  input  4*NDIG  operand B, same packing.
- cin  input  1  decimal carry into digit 0.
- busy  output  1  high while digits are being processed.
- done  output  1  one-cycle pulse when sum/cout become valid.
- sum  output  4*NDIG  packed BCD result.
- cout  output  1  decimal carry out of the top digit.
- invalid  output  1  high if any captured operand digit was greater than 9.

Interface: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - State goes to IDLE and the digit counter clears.
  - busy=0, done=0, sum=0, cout=0, invalid=0; internal operand and carry registers clear.
  - No partial result survives.
- States:
  - IDLE: wait for start.
  - RUN: one digit per cycle.
  - DONE: single-cycle result announcement.
- Start acceptance:
  - start is accepted on a rising edge where start=1 and the state is IDLE or DONE.
  - On acceptance: latch a, b; carry register ← cin; idx ← 0; sum ← 0; cout ← 0; invalid ← OR over all digits of a and b of (digit > 9); state → RUN.
  - While in RUN, start is ignored and operands are not re-sampled.
- RUN, each cycle:
  - Digit adder computes t = a[idx] + b[idx] + carry (5-bit).
  - If t > 9: s = (t + 6)[3:0] and c = 1. Otherwise s = t[3:0] and c = 0.
  - On the clock edge, sum digit idx ← s, carry ← c, idx ← idx + 1.
  - When idx = NDIG−1: cout ← c and state → DONE.
- DONE: done=1 for exactly that cycle; state → IDLE, or RUN if start is accepted.
- Latency:
  - Start sampled at edge E.
  - busy is high for the NDIG cycles following E.
  - done is high in cycle E+NDIG+1.
  - Back-to-back throughput is one result every NDIG+1 cycles.
- Output hold: sum, cout and invalid hold their last values from DONE until the next accepted start (or reset); they update digit-wise during RUN.
- busy is a registered decode of state==RUN; done is a registered decode of state==DONE.
- Non-BCD digits:
  - No error stop; the same correction rule applies and the result is defined.
  - Example: 15+0+0 gives digit 5, carry 1.
  - invalid flags the condition.
- Counter: idx never exceeds NDIG−1; no wrap is observable.
- NDIG=1: RUN lasts a single cycle.

Decomposition:
- Shared package bcd_pkg holds:
  - localparams BCD_MAX=9 and BCD_ADJ=6;
  - the state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- One combinational sub-module, bcd_digit_add (4-bit a, b, cin → 4-bit s, cout), implements the digit rule. It is the only arithmetic in the block; the controller holds the FSM, counter, operand muxing by idx and result registers.

Test Plan:
- NDIG=4, a=16'h0999, b=16'h0001, cin=0, start pulsed → busy high 4 cycles, done on the 5th cycle after the start edge, sum=16'h1000, cout=0, invalid=0.
- a=16'h9999, b=16'h9999, cin=1 → sum=16'h9999, cout=1; then a=16'h9999, b=16'h0001, cin=0 issued in the DONE cycle → accepted back-to-back, sum=16'h0000, cout=1.
- a=16'h000F, b=16'h0000, cin=0 → invalid=1, sum=16'h0015, cout=0; a=16'h0009, b=16'h0009 → sum=16'h0018, invalid=0.
- start held high continuously with changing a and b during RUN → operands are not re-sampled, a single done per NDIG+1 cycles, results match the operands latched at each acceptance.
- rst asserted asynchronously (between edges) in the 2nd RUN cycle → busy, done, sum, cout and invalid go to 0 immediately; after release, a fresh start with a=16'h1234, b=16'h4321 gives sum=16'h5555.
- No start for 20 cycles after reset → done never pulses and all outputs stay 0.
